// File: rtl/single_exp_range_reduce.sv
// Range reduction front end for single-precision exp/exp2: t = a*log2(e) (or a),
// split into integer n = floor(t + 0.5) and fraction f = t - n as a single.
module single_exp_range_reduce #(
  parameter int unsigned MODE_E = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [31:0]        a,
  output logic               out_valid,
  output logic [31:0]        fpart,
  output logic signed [8:0]  n,
  output logic               ovf,
  output logic               unf,
  output logic               nan
);

  localparam logic [23:0] Log2eSig = 24'hB8AA3B;

  // Pipeline state: input capture, then five processing stages (s5 = output regs)
  logic               in_valid_q, s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
  logic [31:0]        a_q;
  logic               s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [7:0]         s1_exp_q;
  logic [23:0]        s1_sig_q;
  logic               s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q;
  logic signed [9:0]  s2_e_q;
  logic [23:0]        s2_sig_q;
  logic signed [33:0] s3_t_q;
  logic               s3_nan_q, s3_ovf_q, s3_unf_q;
  logic signed [8:0]  s4_n_q;
  logic signed [24:0] s4_f_q;
  logic               s4_nan_q, s4_ovf_q, s4_unf_q;

  // Stage 2: significand scaling by log2(e)
  logic [47:0]        prod;
  logic [24:0]        prod_top;
  logic [23:0]        s2_sig_d;
  logic signed [9:0]  s2_e_d;

  always_comb begin
    prod     = {24'd0, s1_sig_q} * {24'd0, Log2eSig};
    prod_top = 25'(prod >> 23);
    s2_e_d   = $signed({2'b00, s1_exp_q}) - 10'sd127;
    s2_sig_d = s1_sig_q;
    if (MODE_E != 0) begin
      if (prod_top[24]) begin
        s2_sig_d = prod_top[24:1];
        s2_e_d   = s2_e_d + 10'sd1;
      end else begin
        s2_sig_d = prod_top[23:0];
      end
    end
  end

  // Stage 3: float to Q9.24 with saturation detection
  logic signed [9:0]  sh;
  logic [9:0]         rs;
  logic [31:0]        mag;
  logic signed [33:0] s3_t_d;
  logic               s3_ovf_d, s3_unf_d;

  always_comb begin
    sh       = s2_e_q + 10'sd1;
    rs       = 10'(-sh);
    mag      = '0;
    s3_t_d   = '0;
    s3_ovf_d = 1'b0;
    s3_unf_d = 1'b0;
    if (s2_nan_q) begin
      s3_t_d = '0;
    end else if (s2_inf_q || (!s2_zero_q && s2_e_q > 10'sd6)) begin
      // |t| >= 128: positive overflows, negative is far below -126
      s3_ovf_d = !s2_sign_q;
      s3_unf_d = s2_sign_q;
    end else if (!s2_zero_q) begin
      if (sh >= 10'sd0) mag = {8'd0, s2_sig_q} << sh[2:0];
      else              mag = {8'd0, s2_sig_q} >> rs;
      if (s2_sign_q && mag > 32'h7E00_0000) s3_unf_d = 1'b1;
      else s3_t_d = s2_sign_q ? -$signed({2'b00, mag}) : $signed({2'b00, mag});
    end
  end

  // Stage 4: round to nearest integer, ties toward +inf
  logic signed [33:0] sum, f_full;
  logic signed [9:0]  n_full;
  logic signed [8:0]  s4_n_d;

  always_comb begin
    sum    = s3_t_q + 34'sd8388608;
    n_full = 10'(sum >>> 24);
    f_full = s3_t_q - $signed({n_full, 24'd0});
    s4_n_d = n_full[8:0];
    if (s3_nan_q)      s4_n_d = 9'sd0;
    else if (s3_ovf_q) s4_n_d = 9'sd128;
    else if (s3_unf_q) s4_n_d = -9'sd127;
  end

  // Stage 5: exact fixed to float conversion of f
  logic [23:0] m;
  logic [4:0]  p;
  logic [7:0]  fe;
  logic [22:0] fm;
  logic [31:0] fpart_d;

  always_comb begin
    m = 24'(s4_f_q[24] ? -s4_f_q : s4_f_q);
    p = '0;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) p = 5'(i);
    end
    fe = 8'd103 + {3'd0, p};
    fm = 23'(m << (5'd23 - p));
    if (s4_nan_q)                  fpart_d = 32'h7FC0_0000;
    else if (s4_ovf_q || s4_unf_q) fpart_d = '0;
    else if (m == '0)              fpart_d = '0;
    else                           fpart_d = {s4_f_q[24], fe, fm};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s4_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      fpart      <= '0;
      n          <= '0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      nan        <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      s1_valid_q <= in_valid_q;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s4_valid_q <= s3_valid_q;
      out_valid  <= s4_valid_q;
      if (s4_valid_q) begin
        fpart <= fpart_d;
        n     <= s4_n_q;
        ovf   <= s4_ovf_q;
        unf   <= s4_unf_q;
        nan   <= s4_nan_q;
      end
    end
  end

  // Datapath registers advance only with their valid bit
  always_ff @(posedge clk) begin
    if (in_valid) a_q <= a;
    if (in_valid_q) begin
      s1_sign_q <= a_q[31];
      s1_exp_q  <= a_q[30:23];
      s1_sig_q  <= {1'b1, a_q[22:0]};
      s1_nan_q  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] != '0);
      s1_inf_q  <= (a_q[30:23] == 8'hFF) && (a_q[22:0] == '0);
      s1_zero_q <= (a_q[30:23] == 8'h00);
    end
    if (s1_valid_q) begin
      s2_sign_q <= s1_sign_q;
      s2_e_q    <= s2_e_d;
      s2_sig_q  <= s2_sig_d;
      s2_nan_q  <= s1_nan_q;
      s2_inf_q  <= s1_inf_q;
      s2_zero_q <= s1_zero_q;
    end
    if (s2_valid_q) begin
      s3_t_q   <= s3_t_d;
      s3_nan_q <= s2_nan_q;
      s3_ovf_q <= s3_ovf_d;
      s3_unf_q <= s3_unf_d;
    end
    if (s3_valid_q) begin
      s4_n_q   <= s4_n_d;
      s4_f_q   <= 25'(f_full);
      s4_nan_q <= s3_nan_q;
      s4_ovf_q <= s3_ovf_q;
      s4_unf_q <= s3_unf_q;
    end
  end

endmodule

// File: tb/tb_single_exp_range_reduce.sv
// Directed bench for single_exp_range_reduce: exp2 (MODE_E=0) and exp (MODE_E=1)
// instances share stimulus; expected values are hand-computed per vector.
module tb_single_exp_range_reduce;

  logic        clk = 1'b0;
  logic        rst, in_valid;
  logic [31:0] a;
  logic        ov0, ovf0, unf0, nan0, ov1, ovf1, unf1, nan1;
  logic [31:0] fp0, fp1;
  logic [8:0]  n0, n1;

  always #5 clk = ~clk;

  single_exp_range_reduce #(.MODE_E(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .out_valid(ov0),
    .fpart(fp0), .n(n0), .ovf(ovf0), .unf(unf0), .nan(nan0)
  );

  single_exp_range_reduce #(.MODE_E(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .out_valid(ov1),
    .fpart(fp1), .n(n1), .ovf(ovf1), .unf(unf1), .nan(nan1)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [8:0]  n0;
    logic [31:0] f0;
    logic [2:0]  fl0;   // {nan, ovf, unf}
    bit          chk1;
    logic [8:0]  n1;
    logic [31:0] f1;
    logic [2:0]  fl1;
    int unsigned tol1;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];
  int unsigned total = 0, passed = 0;

  function automatic vec_t mk(input string nm, input logic [31:0] aa, input logic [8:0] nn0,
                              input logic [31:0] ff0, input logic [2:0] fl0, input bit c1,
                              input logic [8:0] nn1, input logic [31:0] ff1,
                              input logic [2:0] fl1, input int unsigned t1);
    vec_t v;
    v.name = nm; v.a = aa; v.n0 = nn0; v.f0 = ff0; v.fl0 = fl0;
    v.chk1 = c1; v.n1 = nn1; v.f1 = ff1; v.fl1 = fl1; v.tol1 = t1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp,
                     input int unsigned tol);
    logic [31:0] d;
    total++;
    d = (act > exp) ? act - exp : exp - act;
    if (!$isunknown(act) && d <= tol) passed++;
    else $display("FAIL %s: got %08h want %08h", name, act, exp);
  endtask

  task automatic chk_outs(input string tag, input int idx);
    vec_t v;
    v = vecs[idx];
    chk($sformatf("%s %s m0 valid", tag, v.name), {31'd0, ov0}, 32'd1, 0);
    chk($sformatf("%s %s m0 n", tag, v.name), {23'd0, n0}, {23'd0, v.n0}, 0);
    chk($sformatf("%s %s m0 fpart", tag, v.name), fp0, v.f0, 0);
    chk($sformatf("%s %s m0 flags", tag, v.name), {29'd0, nan0, ovf0, unf0}, {29'd0, v.fl0}, 0);
    chk($sformatf("%s %s m1 valid", tag, v.name), {31'd0, ov1}, 32'd1, 0);
    if (v.chk1) begin
      chk($sformatf("%s %s m1 n", tag, v.name), {23'd0, n1}, {23'd0, v.n1}, 0);
      chk($sformatf("%s %s m1 fpart", tag, v.name), fp1, v.f1, v.tol1);
      chk($sformatf("%s %s m1 flags", tag, v.name), {29'd0, nan1, ovf1, unf1},
          {29'd0, v.fl1}, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, {30'd0, ov0, ov1}, 32'd0, 0);
    chk({tag, " fpart0"}, fp0, 32'd0, 0);
    chk({tag, " fpart1"}, fp1, 32'd0, 0);
    chk({tag, " n"}, {14'd0, n0, n1}, 32'd0, 0);
    chk({tag, " flags"}, {26'd0, nan0, ovf0, unf0, nan1, ovf1, unf1}, 32'd0, 0);
  endtask

  // One isolated sample: silent through edge k+4, result at k+5, held at k+6
  task automatic run_vec(input int idx);
    in_valid = 1'b1;
    a        = vecs[idx].a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = '0;
    repeat (3) @(posedge clk);
    @(posedge clk); #1;
    chk($sformatf("lat4 %s", vecs[idx].name), {30'd0, ov0, ov1}, 32'd0, 0);
    @(posedge clk); #1;
    chk_outs("vec", idx);
    @(posedge clk); #1;
    chk($sformatf("idle %s", vecs[idx].name), {30'd0, ov0, ov1}, 32'd0, 0);
    chk($sformatf("hold %s", vecs[idx].name), fp0, vecs[idx].f0, 0);
  endtask

  logic vh [32];
  int   ih [32];

  initial begin
    vecs[0]  = mk("2.75",     32'h4030_0000, 9'h003, 32'hBE80_0000, 3'b000,
                  1'b0, 9'h000, 32'h0, 3'b000, 0);
    vecs[1]  = mk("-1.25",    32'hBFA0_0000, 9'h1FF, 32'hBE80_0000, 3'b000,
                  1'b0, 9'h000, 32'h0, 3'b000, 0);
    vecs[2]  = mk("0.5",      32'h3F00_0000, 9'h001, 32'hBF00_0000, 3'b000,
                  1'b1, 9'h001, 32'hBE8E_AB8A, 3'b000, 0);
    vecs[3]  = mk("-0.5",     32'hBF00_0000, 9'h000, 32'hBF00_0000, 3'b000,
                  1'b1, 9'h1FF, 32'h3E8E_AB8A, 3'b000, 0);
    vecs[4]  = mk("1.0",      32'h3F80_0000, 9'h001, 32'h0000_0000, 3'b000,
                  1'b1, 9'h001, 32'h3EE2_A8ED, 3'b000, 1);
    vecs[5]  = mk("2.0",      32'h4000_0000, 9'h002, 32'h0000_0000, 3'b000,
                  1'b1, 9'h003, 32'hBDEA_B8A0, 3'b000, 0);
    vecs[6]  = mk("-1.0",     32'hBF80_0000, 9'h1FF, 32'h0000_0000, 3'b000,
                  1'b1, 9'h1FF, 32'hBEE2_A8EC, 3'b000, 0);
    vecs[7]  = mk("+200",     32'h4348_0000, 9'h080, 32'h0, 3'b010,
                  1'b1, 9'h080, 32'h0, 3'b010, 0);
    vecs[8]  = mk("-200",     32'hC348_0000, 9'h181, 32'h0, 3'b001,
                  1'b1, 9'h181, 32'h0, 3'b001, 0);
    vecs[9]  = mk("qnan",     32'h7FC0_0000, 9'h000, 32'h7FC0_0000, 3'b100,
                  1'b1, 9'h000, 32'h7FC0_0000, 3'b100, 0);
    vecs[10] = mk("+inf",     32'h7F80_0000, 9'h080, 32'h0, 3'b010,
                  1'b1, 9'h080, 32'h0, 3'b010, 0);
    vecs[11] = mk("-inf",     32'hFF80_0000, 9'h181, 32'h0, 3'b001,
                  1'b1, 9'h181, 32'h0, 3'b001, 0);
    vecs[12] = mk("denorm",   32'h0000_0001, 9'h000, 32'h0, 3'b000,
                  1'b1, 9'h000, 32'h0, 3'b000, 0);
    vecs[13] = mk("-zero",    32'h8000_0000, 9'h000, 32'h0, 3'b000,
                  1'b1, 9'h000, 32'h0, 3'b000, 0);
    vecs[14] = mk("127",      32'h42FE_0000, 9'h07F, 32'h0, 3'b000,
                  1'b1, 9'h080, 32'h0, 3'b010, 0);
    vecs[15] = mk("128",      32'h4300_0000, 9'h080, 32'h0, 3'b010,
                  1'b1, 9'h080, 32'h0, 3'b010, 0);
    vecs[16] = mk("-126",     32'hC2FC_0000, 9'h182, 32'h0, 3'b000,
                  1'b1, 9'h181, 32'h0, 3'b001, 0);
    vecs[17] = mk("-126.5",   32'hC2FD_0000, 9'h181, 32'h0, 3'b001,
                  1'b1, 9'h181, 32'h0, 3'b001, 0);
    vecs[18] = mk("2^-24",    32'h3380_0000, 9'h000, 32'h3380_0000, 3'b000,
                  1'b1, 9'h000, 32'h3380_0000, 3'b000, 0);
    vecs[19] = mk("2^-26",    32'h3280_0000, 9'h000, 32'h0, 3'b000,
                  1'b1, 9'h000, 32'h0, 3'b000, 0);
    vecs[20] = mk("-nan",     32'hFF80_0001, 9'h000, 32'h7FC0_0000, 3'b100,
                  1'b1, 9'h000, 32'h7FC0_0000, 3'b100, 0);

    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-to-back stream with a trailing gap
    for (int c = 0; c < 28; c++) begin
      vh[c]    = (c < 20);
      ih[c]    = (c * 5 + 3) % NV;
      in_valid = vh[c];
      a        = vh[c] ? vecs[ih[c]].a : 32'h0;
      @(posedge clk); #1;
      if (c >= 5 && vh[c-5]) chk_outs($sformatf("stream%0d", c - 5), ih[c-5]);
      else chk($sformatf("stream gap c%0d", c), {30'd0, ov0, ov1}, 32'd0, 0);
    end

    // Reset with four samples in flight
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a        = vecs[2 + i].a;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    a        = '0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("midrst");
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stale c%0d", c), {30'd0, ov0, ov1}, 32'd0, 0);
    end
    run_vec(4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
